// File: rtl/fir_out_fifo.sv
// Output buffer for the FIR sample stream: a first-word fall-through FIFO
// with a level output, a sticky overflow flag and a saturating drop counter.
module fir_out_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16,
  parameter int AW     = $clog2(DEPTH),
  parameter int LW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_sample,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [LW-1:0]     level,
  output logic              overflow,
  output logic [CNT_W-1:0]  drop_count,
  input  logic              clr_status
);

  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic              pop, push, drop;

  always_comb begin
    pop  = (cnt_q != '0) && m_ready;
    push = in_valid && ((cnt_q != FULL) || pop);
    drop = in_valid && (cnt_q == FULL) && !pop;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_sample;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + LW'(1);
      2'b01:   cnt_d = cnt_q - LW'(1);
      default: cnt_d = cnt_q;
    endcase

    // A drop in the clear cycle survives the clear as the first count.
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (clr_status) begin
      ovf_d  = drop;
      drop_d = drop ? CNT_W'(1) : '0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (!(&drop_q)) begin
        drop_d = drop_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  assign m_valid    = (cnt_q != '0);
  assign m_data     = m_valid ? mem_q[rd_ptr_q] : '0;
  assign level      = cnt_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_fir_out_fifo.sv
// Directed bench for fir_out_fifo: reset, overflow, full-rate streaming,
// counter saturation and clear, FIR impulse stream, mid-stream reset.
module tb_fir_out_fifo;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 4;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [DATA_W-1:0] in_sample;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [LW-1:0]     level;
  logic              overflow;
  logic [CNT_W-1:0]  drop_count;
  logic              clr_status;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  fir_out_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_sample (in_sample),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .level     (level),
    .overflow  (overflow),
    .drop_count(drop_count),
    .clr_status(clr_status)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    in_valid   = 1'($urandom);
    in_sample  = 16'($urandom);
    m_ready    = 1'($urandom);
    clr_status = 1'($urandom);
    tick();
    tick();
    nvec++;
    if ({m_valid, m_data, level, overflow, drop_count} !== '0) begin
      nerr++;
      $display("FAIL reset_vals: got v=%b d=%h l=%0d o=%b c=%0d want all 0",
               m_valid, m_data, level, overflow, drop_count);
    end
    in_valid   = 1'b0;
    in_sample  = '0;
    m_ready    = 1'b0;
    clr_status = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    tick();
    tick();
    nvec++;
    if ({m_valid, m_data, level, overflow, drop_count} !== '0) begin
      nerr++;
      $display("FAIL post_reset_idle: got v=%b d=%h l=%0d o=%b c=%0d want all 0",
               m_valid, m_data, level, overflow, drop_count);
    end
  endtask

  task automatic test_fill_overflow();
    m_ready = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      in_valid  = 1'b1;
      in_sample = 16'(i);
      tick();
      if (i == 1) begin
        nvec++;
        if (m_valid !== 1'b1 || m_data !== 16'h0001 || level !== 5'd1) begin
          nerr++;
          $display("FAIL first_push_latency: got v=%b d=%h l=%0d want 1/0001/1",
                   m_valid, m_data, level);
        end
      end
    end
    in_valid = 1'b0;
    nvec++;
    if (level !== 5'd16 || overflow !== 1'b1 || drop_count !== 4'd1) begin
      nerr++;
      $display("FAIL fill_ovf: got l=%0d o=%b c=%0d want 16/1/1",
               level, overflow, drop_count);
    end
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      nvec++;
      if (m_valid !== 1'b1 || m_data !== 16'(i)) begin
        nerr++;
        $display("FAIL fill_drain[%0d]: got v=%b d=%h want 1/%h",
                 i, m_valid, m_data, 16'(i));
      end
      tick();
    end
    tick();
    m_ready = 1'b0;
    nvec++;
    if (m_valid !== 1'b0 || level !== 5'd0 || m_data !== 16'h0000) begin
      nerr++;
      $display("FAIL fill_empty: got v=%b l=%0d d=%h want 0/0/0000",
               m_valid, level, m_data);
    end
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    nvec++;
    if (overflow !== 1'b0 || drop_count !== 4'd0) begin
      nerr++;
      $display("FAIL fill_clr: got o=%b c=%0d want 0/0", overflow, drop_count);
    end
  endtask

  task automatic test_back_to_back();
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_valid  = 1'b1;
      in_sample = 16'(16'h0100 + i);
      tick();
    end
    for (int k = 0; k < 40; k++) begin
      in_valid  = 1'b1;
      in_sample = 16'(16'h0110 + k);
      m_ready   = 1'b1;
      nvec++;
      if (level !== 5'd16 || m_data !== 16'(16'h0100 + k)) begin
        nerr++;
        $display("FAIL b2b[%0d]: got l=%0d d=%h want 16/%h",
                 k, level, m_data, 16'(16'h0100 + k));
      end
      tick();
    end
    in_valid = 1'b0;
    nvec++;
    if (level !== 5'd16 || overflow !== 1'b0 || drop_count !== 4'd0) begin
      nerr++;
      $display("FAIL b2b_nodrop: got l=%0d o=%b c=%0d want 16/0/0",
               level, overflow, drop_count);
    end
    for (int k = 40; k < 56; k++) begin
      nvec++;
      if (m_valid !== 1'b1 || m_data !== 16'(16'h0100 + k)) begin
        nerr++;
        $display("FAIL b2b_drain[%0d]: got v=%b d=%h want 1/%h",
                 k, m_valid, m_data, 16'(16'h0100 + k));
      end
      tick();
    end
    m_ready = 1'b0;
    nvec++;
    if (m_valid !== 1'b0 || level !== 5'd0) begin
      nerr++;
      $display("FAIL b2b_empty: got v=%b l=%0d want 0/0", m_valid, level);
    end
  endtask

  task automatic test_saturation();
    m_ready = 1'b0;
    for (int i = 0; i < 36; i++) begin
      in_valid  = 1'b1;
      in_sample = 16'(16'hA000 + i);
      tick();
    end
    in_valid = 1'b0;
    nvec++;
    if (level !== 5'd16 || overflow !== 1'b1 || drop_count !== 4'd15) begin
      nerr++;
      $display("FAIL sat: got l=%0d o=%b c=%0d want 16/1/15",
               level, overflow, drop_count);
    end
    clr_status = 1'b1;
    tick();
    nvec++;
    if (overflow !== 1'b0 || drop_count !== 4'd0) begin
      nerr++;
      $display("FAIL sat_clr: got o=%b c=%0d want 0/0", overflow, drop_count);
    end
    in_valid  = 1'b1;
    in_sample = 16'hDEAD;
    tick();
    in_valid   = 1'b0;
    clr_status = 1'b0;
    nvec++;
    if (overflow !== 1'b1 || drop_count !== 4'd1 || level !== 5'd16) begin
      nerr++;
      $display("FAIL sat_clr_drop: got o=%b c=%0d l=%0d want 1/1/16",
               overflow, drop_count, level);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      nvec++;
      if (m_data !== 16'(16'hA000 + i)) begin
        nerr++;
        $display("FAIL sat_drain[%0d]: got %h want %h",
                 i, m_data, 16'(16'hA000 + i));
      end
      tick();
    end
    m_ready    = 1'b0;
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
  endtask

  task automatic test_stream();
    logic [DATA_W-1:0] h [16];
    int sent = 0;
    int rcvd = 0;
    int cyc  = 0;
    // 0x7FFF impulse through a 16-tap core, as signed Q1.15 words.
    h = '{16'h0000, 16'h7FFF, 16'h4000, 16'hC000, 16'h2000, 16'hE000,
          16'h8001, 16'h1000, 16'hF000, 16'h0800, 16'hF800, 16'h0400,
          16'hFC00, 16'h0200, 16'hFE00, 16'h0001};
    while (rcvd < 16 && cyc < 300) begin
      m_ready   = 1'($urandom);
      in_valid  = (sent < 16);
      in_sample = (sent < 16) ? h[sent] : '0;
      if (m_valid && m_ready) begin
        nvec++;
        if (m_data !== h[rcvd]) begin
          nerr++;
          $display("FAIL stream[%0d]: got %h want %h", rcvd, m_data, h[rcvd]);
        end
        rcvd++;
      end
      tick();
      if (in_valid) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    m_ready  = 1'b0;
    nvec++;
    if (rcvd != 16 || drop_count !== 4'd0 || m_valid !== 1'b0) begin
      nerr++;
      $display("FAIL stream_end: got rcvd=%0d c=%0d v=%b want 16/0/0",
               rcvd, drop_count, m_valid);
    end
  endtask

  task automatic test_reset_midstream();
    m_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_valid  = 1'b1;
      in_sample = 16'(16'h5500 + i);
      tick();
    end
    in_valid = 1'b0;
    nvec++;
    if (level !== 5'd9) begin
      nerr++;
      $display("FAIL mid_level: got %0d want 9", level);
    end
    #1 rst_n = 1'b0;
    #1;
    nvec++;
    if (level !== 5'd0 || m_valid !== 1'b0 || m_data !== 16'h0000) begin
      nerr++;
      $display("FAIL mid_rst: got l=%0d v=%b d=%h want 0/0/0000",
               level, m_valid, m_data);
    end
    #1 rst_n = 1'b1;
    tick();
    in_valid  = 1'b1;
    in_sample = 16'h1234;
    tick();
    in_valid = 1'b0;
    nvec++;
    if (m_valid !== 1'b1 || m_data !== 16'h1234 || level !== 5'd1) begin
      nerr++;
      $display("FAIL mid_first: got v=%b d=%h l=%0d want 1/1234/1",
               m_valid, m_data, level);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    nvec++;
    if (m_valid !== 1'b0 || level !== 5'd0) begin
      nerr++;
      $display("FAIL mid_pop: got v=%b l=%0d want 0/0", m_valid, level);
    end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_back_to_back();
    test_saturation();
    test_stream();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fir_out_fifo.md
# fir_out_fifo

Receive-side buffer for the filter output stream. Captures every `in_valid`/`in_sample` beat from the FIR core, which has no backpressure, into a synchronous FIFO. Presents the samples downstream on a valid/ready interface. Reports buffer level, a sticky overflow flag and a saturating count of dropped samples.

## Interface

Parameters:
- `DATA_W`, 16, sample width (signed Q1.15).
- `DEPTH`, 16, FIFO depth in samples; power of two, ≥ 2.
- `CNT_W`, 16, width of the drop counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low; clears all state.
- `in_valid`  in  1  sample strobe from the FIR output; no ready is returned.
- `in_sample`  in  DATA_W  signed sample, qualified by `in_valid`.
- `m_valid`  out  1  FIFO non-empty; `m_data` holds the oldest sample.
- `m_ready`  in  1  downstream accepts; a pop occurs when `m_valid && m_ready`.
- `m_data`  out  DATA_W  oldest stored sample (first-word fall-through); 0 when empty.
- `level`  out  $clog2(DEPTH)+1  number of stored samples, 0..DEPTH.
- `overflow`  out  1  sticky; set when a sample is dropped.
- `drop_count`  out  CNT_W  dropped-sample count; saturates at all-ones.
- `clr_status`  in  1  synchronous clear of `overflow` and `drop_count`.

## Operation

- Storage: DEPTH×DATA_W register array, write pointer and read pointer of $clog2(DEPTH) bits, each wrapping modulo DEPTH, plus an occupancy counter driving `level`.
- Pop:
  - `pop = m_valid && m_ready`.
  - A pop advances the read pointer and decrements the occupancy counter.
  - `m_ready` while empty has no effect.
- Push:
  - `push = in_valid && (level < DEPTH || pop)`.
  - A push writes `in_sample` at the write pointer and advances the pointer.
  - When full, a sample arriving in the same cycle as a pop is accepted.
- Push and pop in the same cycle leave `level` unchanged.
  - This includes the empty case? No: when empty, `m_valid` = 0, so no pop occurs and only the push takes effect.
- Drop:
  - `drop = in_valid && level == DEPTH && !pop`.
  - On a drop, the sample is discarded, `overflow` ← 1, and `drop_count` increments unless already all-ones.
  - FIFO contents and pointers are unchanged.
- `clr_status` = 1 without a drop: `overflow` ← 0, `drop_count` ← 0.
- `clr_status` = 1 with a drop in the same cycle: the drop is counted, giving `overflow` = 1 and `drop_count` = 1.
- `m_data` = storage[read pointer] when `level` ≠ 0, else 0. This read is combinational from registers.
- Data is not modified: no rescaling and no saturation. Sign bits are carried as-is.
- Samples are delivered in arrival order with no duplication.

## Timing

- Reset (asynchronous, `rst_n` = 0):
  - Pointers = 0, `level` = 0, `m_valid` = 0, `m_data` = 0, `overflow` = 0, `drop_count` = 0.
  - Storage contents need not be reset.
- Reset asserted mid-operation flushes all buffered samples immediately. The first `in_valid` after deassertion is stored at slot 0.
- Latency:
  - A sample pushed at edge k is visible on `m_valid`/`m_data` after edge k when the FIFO was empty.
  - There is no combinational path from `in_valid` to `m_valid`.
- `level`, `overflow` and `drop_count` update on the same edge as the causing event.
- `m_valid` depends only on registered state. It never depends combinationally on `m_ready`.
- Throughput: one push and one pop per cycle, sustained indefinitely.
- Pointer wrap from DEPTH-1 to 0 is seamless. `level` never exceeds DEPTH and never underflows.

## Test plan

- Reset values: assert `rst_n` = 0 with random inputs -> all outputs 0. After release, hold `m_ready` = 0, `in_valid` = 0 -> outputs stay 0.
- Fill and overflow (DEPTH = 16): `m_ready` = 0, push 0x0001..0x0011 on 17 consecutive cycles.
  - Required: `level` = 16, `overflow` = 1, `drop_count` = 1.
  - Then `m_ready` = 1 -> pops return 0x0001..0x0010 in order, then `m_valid` = 0.
- Full with simultaneous push/pop: fill to 16, then `in_valid` = 1 and `m_ready` = 1 for 40 cycles with an incrementing pattern.
  - Required: `level` stays 16, no drops, output sequence contiguous across pointer wrap.
- Saturation and clear (CNT_W = 4): drive `in_valid` continuously while full for 20 cycles -> `drop_count` = 15.
  - `clr_status` alone -> 0/0.
  - `clr_status` coinciding with a drop -> `overflow` = 1, `drop_count` = 1.
- Streaming from the FIR core: core fed an impulse 0x7FFF, `m_ready` random at 50%.
  - Required: captured sequence equals the core's `out_sample` sequence exactly, and `drop_count` = 0.
- Reset mid-stream: with `level` = 9, pulse `rst_n` low -> `level` = 0 and `m_valid` = 0 immediately. Next pushed value 0x1234 -> first `m_data` = 0x1234.
